cmd_parser: RTL
===============

# cmd_parser

Byte-to-command assembler for the SUMP/OLS protocol, sitting between the UART receiver and the instruction decoder. It consumes one received byte per strobe and classifies it: a byte with bit 7 clear is a complete short command, and a byte with bit 7 set opens a long command followed by four data bytes. Each complete command is presented as a one-cycle strobe with a stable opcode and 32-bit argument, which the decoder and configuration registers consume.

## Interface
- TMO_CYCLES, default 1_000_000: idle cycles allowed between bytes of a long command before it is aborted (used only with the timeout feature).
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- rx_dat_i  in  8  received byte.
- rx_stb_i  in  1  one-cycle flag: rx_dat_i is valid.
- stb_o  out  1  one-cycle pulse: complete command available.
- opc_o  out  8  opcode of the last completed command.
- cmd_o  out  32  argument of the last completed command.
- busy_o  out  1  a long command is partially received.
- tmo_o  out  1  one-cycle pulse: a partial long command was discarded on timeout.

## Operation
- Reset (rst_i sampled high at a clock edge): state IDLE; stb_o, busy_o, tmo_o = 0; opc_o = 8'h00; cmd_o = 32'h0; byte counter = 0.
- FSM states: IDLE, ARGS.
- IDLE, rx_stb_i with rx_dat_i[7] = 0: opc_o <= rx_dat_i, cmd_o <= 0, stb_o <= 1; remain in IDLE.
- IDLE, rx_stb_i with rx_dat_i[7] = 1: the byte is latched as the pending opcode, counter <= 0, and the FSM moves to ARGS. opc_o and cmd_o are not changed yet.
- ARGS, rx_stb_i: the byte is stored into argument byte[counter]. The first data byte is the LSB, so byte n goes to bits [8n+7:8n]. The counter increments.
- ARGS, fourth data byte (counter = 3): opc_o <= pending opcode, cmd_o <= the assembled argument including this byte, stb_o <= 1, and the FSM returns to IDLE.
- In ARGS, a byte with bit 7 set is treated as data, never as a new opcode.
- opc_o and cmd_o hold their values until the next completed command. Partially received long commands never disturb them.
- busy_o = 1 exactly while the FSM is in ARGS.
- rx_stb_i is ignored when it is low. There is no back-pressure; every strobed byte is consumed.

## Timing
- Latency: stb_o rises on the edge after the clock in which the final byte is strobed, i.e. one cycle after a short opcode or after the fourth data byte.
- stb_o is exactly one cycle wide, and opc_o/cmd_o are valid in that same cycle.
- Back-to-back bytes (rx_stb_i high on consecutive cycles) are accepted without loss. A byte strobed in the cycle stb_o is high is processed in IDLE as a new opcode.
- Minimum spacing is therefore 1 cycle per short command and 5 cycles per long command.
- rst_i has priority over all other inputs. Asserting it mid-ARGS discards the partial command, and no stb_o follows.

## Configuration
- Macro: CMD_PARSER_TIMEOUT_EN.
- Defined:
  - An idle counter is reset to 0 on entering ARGS and on every accepted byte in ARGS. It increments each cycle in ARGS without rx_stb_i.
  - When it reaches TMO_CYCLES-1 with no byte in that cycle, the FSM returns to IDLE, the partial data is discarded, and tmo_o pulses for one cycle. opc_o/cmd_o are unchanged.
  - The counter width is $clog2(TMO_CYCLES).
  - A byte arriving in the expiry cycle takes precedence, and no timeout occurs.
- Undefined: there is no counter, tmo_o is tied to 0, and ARGS waits indefinitely.

## Structure
- logIP_pkg gains:
  - cmd_parser_state_t, an enum {IDLE, ARGS}.
  - CMD_LONG_BIT = 7.
  - CMD_ARG_BYTES = 4.
- Optional sub-module cmd_tmo holds the idle counter. It has inputs clr_i, en_i and output exp_o, and is instantiated only under CMD_PARSER_TIMEOUT_EN.
- The argument shift/assembly and the FSM stay in cmd_parser.

## Test plan
- Short command: rx byte 8'h02 -> stb_o pulses one cycle later, opc_o = 8'h02, cmd_o = 0, busy_o stays 0.
- Long command: bytes 8'hC0, 8'h11, 8'h22, 8'h33, 8'h44, strobed on consecutive cycles -> one stb_o with opc_o = 8'hC0 and cmd_o = 32'h44332211. busy_o is high for 4 cycles. No stb_o occurs after the opcode byte.
- Data byte with MSB set: 8'h80 followed by 8'hFF ×4 -> single stb_o with opc_o = 8'h80 and cmd_o = 32'hFFFFFFFF.
- Back-to-back: a long command whose last byte is followed on the very next cycle by 8'h01 -> two stb_o pulses one cycle apart, the second carrying opc_o = 8'h01 and cmd_o = 0.
- Reset mid-command: 8'hC0, 8'h11, then rst_i high for 1 cycle, then 8'h00 -> no stb_o for the partial command. stb_o pulses once with opc_o = 8'h00 after the 8'h00 byte.
- Timeout (macro defined, TMO_CYCLES = 8): 8'hC0, 8'h11, then 8 idle cycles -> tmo_o pulses, busy_o drops, and opc_o/cmd_o keep their previous values. A following 8'h02 decodes as a short command.

Source files
------------

// File: rtl/cmd_parser_pkg.sv
// cmd_parser_pkg: shared types and constants for the SUMP/OLS command parser.
package cmd_parser_pkg;

  // Parser FSM: IDLE waits for an opcode, ARGS collects the argument bytes.
  typedef enum logic {
    IDLE = 1'b0,
    ARGS = 1'b1
  } cmd_parser_state_t;

  // Opcode bit that marks a long (five-byte) command.
  localparam int CMD_LONG_BIT  = 7;
  // Number of argument bytes that follow a long opcode.
  localparam int CMD_ARG_BYTES = 4;

  // True when the byte opens a long command.
  function automatic logic is_long(input logic [7:0] b);
    return b[CMD_LONG_BIT];
  endfunction

endpackage

// File: rtl/cmd_parser_if.sv
// cmd_parser_if: byte input and command output bundle of the command parser.
// The slave modport is the parser; the master modport is the byte source
// together with the command consumer.
interface cmd_parser_if;
  logic [7:0]  rx_dat_i;
  logic        rx_stb_i;
  logic        stb_o;
  logic [7:0]  opc_o;
  logic [31:0] cmd_o;
  logic        busy_o;
  logic        tmo_o;

  modport slave (
    input  rx_dat_i,
    input  rx_stb_i,
    output stb_o,
    output opc_o,
    output cmd_o,
    output busy_o,
    output tmo_o
  );

  modport master (
    output rx_dat_i,
    output rx_stb_i,
    input  stb_o,
    input  opc_o,
    input  cmd_o,
    input  busy_o,
    input  tmo_o
  );
endinterface

// File: rtl/cmd_parser_tmo.sv
// cmd_tmo: idle counter that aborts a stalled long command.
// Only compiled and used when CMD_PARSER_TIMEOUT_EN is defined.
`ifdef CMD_PARSER_TIMEOUT_EN
module cmd_tmo #(
  parameter int TMO_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic exp_o
);
  localparam int CW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear on any accepted byte, count idle cycles while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is only meaningful in an idle cycle; a byte in that cycle wins.
  assign exp_o = en_i && !clr_i && (cnt_q == CNT_LAST);
endmodule
`endif

// File: rtl/cmd_parser.sv
// cmd_parser: assembles SUMP/OLS bytes into one-cycle command strobes.
// Short commands (bit 7 clear) complete immediately; long commands take four
// LSB-first argument bytes. Optional stall timeout: CMD_PARSER_TIMEOUT_EN.
module cmd_parser
  import cmd_parser_pkg::*;
#(
  parameter int TMO_CYCLES = 1_000_000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  cmd_parser_if.slave   bus
);
  cmd_parser_state_t state_q;
  logic [7:0]        pend_q;
  logic [1:0]        cnt_q;
  logic [31:0]       arg_q;
  logic [31:0]       arg_d;
  logic              stb_q;
  logic              busy_q;
  logic              tmo_q;
  logic [7:0]        opc_q;
  logic [31:0]       cmd_q;
  logic              tmo_exp_s;

`ifdef CMD_PARSER_TIMEOUT_EN
  cmd_tmo #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (bus.rx_stb_i),
    .en_i  (state_q == ARGS),
    .exp_o (tmo_exp_s)
  );
`else
  assign tmo_exp_s = 1'b0;
`endif

  // Argument with the incoming byte merged into its slot (byte n -> bits 8n+7:8n).
  always_comb begin
    arg_d = arg_q;
    arg_d[{cnt_q, 3'b000} +: 8] = bus.rx_dat_i;
  end

  // Parser FSM with registered command outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= 8'h00;
      cnt_q   <= 2'd0;
      arg_q   <= 32'h0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      opc_q   <= 8'h00;
      cmd_q   <= 32'h0;
    end else begin
      stb_q <= 1'b0;
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rx_stb_i) begin
            if (is_long(bus.rx_dat_i)) begin
              pend_q  <= bus.rx_dat_i;
              cnt_q   <= 2'd0;
              state_q <= ARGS;
              busy_q  <= 1'b1;
            end else begin
              opc_q <= bus.rx_dat_i;
              cmd_q <= 32'h0;
              stb_q <= 1'b1;
            end
          end
        end
        ARGS: begin
          if (bus.rx_stb_i) begin
            // Every byte here is data, whatever its top bit.
            arg_q <= arg_d;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'(CMD_ARG_BYTES - 1)) begin
              opc_q   <= pend_q;
              cmd_q   <= arg_d;
              stb_q   <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (tmo_exp_s) begin
            // Stalled long command: drop it, keep last completed command.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stb_o  = stb_q;
  assign bus.opc_o  = opc_q;
  assign bus.cmd_o  = cmd_q;
  assign bus.busy_o = busy_q;
  assign bus.tmo_o  = tmo_q;
endmodule
